// File: rtl/codec_adc_receiver.sv
// Audio codec ADC capture path: generates ADCLRCK and a BCLK replica,
// deserializes left-justified AUD_ADCDAT into 16-bit sample pairs.
module codec_adc_receiver #(
    parameter int BCLK_DIVIDER = 35,
    parameter int LRCK_DIVIDER = 1151,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                    xck_clock,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    aud_adcdat,
    output logic                    aud_adclrck,
    output logic                    bclk_mon,
    output logic [SAMPLE_WIDTH-1:0] left_sample,
    output logic [SAMPLE_WIDTH-1:0] right_sample,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic                    overrun,
    input  logic                    overrun_clear
);

    localparam int BW = $clog2(BCLK_DIVIDER + 1);
    localparam int LW = $clog2(LRCK_DIVIDER + 1);
    localparam int CW = $clog2(SAMPLE_WIDTH + 1);

    logic [BW-1:0]           bclk_cnt;
    logic [LW-1:0]           lrck_cnt;
    logic [CW-1:0]           bit_cnt;
    logic [SAMPLE_WIDTH-1:0] left_sr;
    logic [SAMPLE_WIDTH-1:0] right_sr;
    logic                    adc_q;
    logic                    left_done;
    logic                    pair_done;
    logic                    bclk_wrap;
    logic                    lrck_toggle;
    logic                    bclk_rise;
    logic                    bits_full;

    assign bclk_wrap   = (bclk_cnt == BW'(BCLK_DIVIDER));
    assign lrck_toggle = (lrck_cnt == LW'(LRCK_DIVIDER));
    assign bclk_rise   = bclk_wrap && !bclk_mon;
    assign bits_full   = (bit_cnt == CW'(SAMPLE_WIDTH));

    // Free-running dividers, independent of enable
    always_ff @(posedge xck_clock or negedge rst_n) begin
        if (!rst_n) begin
            bclk_cnt    <= '0;
            bclk_mon    <= 1'b0;
            lrck_cnt    <= '0;
            aud_adclrck <= 1'b0;
        end else begin
            if (bclk_wrap) begin
                bclk_cnt <= '0;
                bclk_mon <= ~bclk_mon;
            end else begin
                bclk_cnt <= bclk_cnt + BW'(1);
            end
            if (lrck_toggle) begin
                lrck_cnt    <= '0;
                aud_adclrck <= ~aud_adclrck;
            end else begin
                lrck_cnt <= lrck_cnt + LW'(1);
            end
        end
    end

    // Bit capture and frame completion tracking
    always_ff @(posedge xck_clock or negedge rst_n) begin
        if (!rst_n) begin
            adc_q     <= 1'b0;
            bit_cnt   <= '0;
            left_sr   <= '0;
            right_sr  <= '0;
            left_done <= 1'b0;
            pair_done <= 1'b0;
        end else begin
            adc_q <= aud_adcdat;
            if (!enable) begin
                bit_cnt   <= '0;
                left_done <= 1'b0;
                pair_done <= 1'b0;
            end else if (lrck_toggle) begin
                bit_cnt <= '0;
                if (aud_adclrck) begin
                    left_done <= bits_full;
                    pair_done <= 1'b0;
                end else begin
                    pair_done <= left_done && bits_full;
                    left_done <= 1'b0;
                end
            end else begin
                pair_done <= 1'b0;
                if (bclk_rise && !bits_full) begin
                    if (aud_adclrck)
                        left_sr <= {left_sr[SAMPLE_WIDTH-2:0], adc_q};
                    else
                        right_sr <= {right_sr[SAMPLE_WIDTH-2:0], adc_q};
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end

    // Output handshake; a pair arriving while one is still pending is dropped
    always_ff @(posedge xck_clock or negedge rst_n) begin
        if (!rst_n) begin
            left_sample  <= '0;
            right_sample <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (pair_done && (!sample_valid || sample_ready)) begin
                left_sample  <= left_sr;
                right_sample <= right_sr;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
            if (pair_done && sample_valid && !sample_ready)
                overrun <= 1'b1;
            else if (overrun_clear)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_codec_adc_receiver.sv
// Bench for codec_adc_receiver: codec serializer model, frame-level
// vector table and hand-written clock/reset sequences.
module tb_codec_adc_receiver;

    logic        xck_clock = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        aud_adcdat;
    logic        aud_adclrck;
    logic        bclk_mon;
    logic [15:0] left_sample;
    logic [15:0] right_sample;
    logic        sample_valid;
    logic        sample_ready;
    logic        overrun;
    logic        overrun_clear;

    logic [15:0] lw;
    logic [15:0] rw;
    int          checks = 0;
    int          errors = 0;

    codec_adc_receiver dut (
        .xck_clock     (xck_clock),
        .rst_n         (rst_n),
        .enable        (enable),
        .aud_adcdat    (aud_adcdat),
        .aud_adclrck   (aud_adclrck),
        .bclk_mon      (bclk_mon),
        .left_sample   (left_sample),
        .right_sample  (right_sample),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .overrun       (overrun),
        .overrun_clear (overrun_clear)
    );

    always #5 xck_clock = ~xck_clock;

    typedef struct {
        logic [15:0] lw;
        logic [15:0] rw;
        logic        en;
        logic        gap;
        logic        rdy;
        logic        rdy_last;
        logic        clr;
        logic        exp_v;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
        logic        exp_o;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge xck_clock);
        #1;
    endtask

    // Codec model: MSB on the BCLK fall that coincides with the LRCK edge
    initial begin : codec
        int   idx;
        logic pb;
        logic pl;
        idx = 16;
        pb = 1'b0;
        pl = 1'b0;
        aud_adcdat = 1'b0;
        forever begin
            @(posedge xck_clock);
            #1;
            if (!rst_n) begin
                idx = 16;
                pb = 1'b0;
                pl = 1'b0;
            end else begin
                if (pb && !bclk_mon) begin
                    if (pl != aud_adclrck) idx = 0;
                    else if (idx < 16) idx++;
                end
                pb = bclk_mon;
                pl = aud_adclrck;
            end
            if (idx < 16)
                aud_adcdat = aud_adclrck ? lw[15-idx] : rw[15-idx];
            else
                aud_adcdat = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t tbl[11];
        int   bad_b, bad_l, bad_v, bad_c, first_rise, early;
        logic pl, pbm;

        tbl[0]  = '{16'hA5C3, 16'h7F01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                    1'b1, 16'hA5C3, 16'h7F01, 1'b0};
        tbl[1]  = '{16'h1111, 16'h2222, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                    1'b1, 16'h1111, 16'h2222, 1'b0};
        tbl[2]  = '{16'h3333, 16'h4444, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                    1'b1, 16'h1111, 16'h2222, 1'b1};
        tbl[3]  = '{16'h5555, 16'h6666, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                    1'b1, 16'h5555, 16'h6666, 1'b1};
        tbl[4]  = '{16'h789A, 16'hBCDE, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                    1'b1, 16'h789A, 16'hBCDE, 1'b0};
        tbl[5]  = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                    1'b0, 16'h789A, 16'hBCDE, 1'b0};
        tbl[6]  = '{16'hABCD, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                    1'b1, 16'hABCD, 16'h1234, 1'b0};
        tbl[7]  = '{16'hCAFE, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                    1'b1, 16'hCAFE, 16'hBEEF, 1'b0};
        tbl[8]  = '{16'h0001, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                    1'b1, 16'h0001, 16'h8000, 1'b0};
        tbl[9]  = '{16'h0F0F, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    1'b1, 16'h0001, 16'h8000, 1'b0};
        tbl[10] = '{16'h5A5A, 16'hA5A5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                    1'b1, 16'h5A5A, 16'hA5A5, 1'b0};

        rst_n = 1'b0;
        enable = 1'b1;
        sample_ready = 1'b1;
        overrun_clear = 1'b0;
        lw = 16'hA5C3;
        rw = 16'h7F01;
        repeat (3) tick();
        check("reset lrck", aud_adclrck, 0);
        check("reset bclk", bclk_mon, 0);
        check("reset left", left_sample, 0);
        check("reset right", right_sample, 0);
        check("reset valid", sample_valid, 0);
        check("reset overrun", overrun, 0);

        // Clock generation and first pair, counted in edges after release
        @(posedge xck_clock);
        #3 rst_n = 1'b1;
        bad_b = 0; bad_l = 0; bad_v = 0; bad_c = 0; first_rise = 0;
        pl = 1'b0; pbm = 1'b0;
        for (int n = 1; n <= 6912; n++) begin
            tick();
            if (bclk_mon !== 1'((n / 36) % 2)) bad_b++;
            if (aud_adclrck !== 1'((n / 1152) % 2)) bad_l++;
            if (sample_valid !== 1'(n == 3457 || n == 5761)) bad_v++;
            if (aud_adclrck && !pl && first_rise == 0) first_rise = n;
            if (aud_adclrck !== pl && !(pbm && !bclk_mon)) bad_c++;
            if (n == 3457) begin
                check("first pair left", left_sample, 16'hA5C3);
                check("first pair right", right_sample, 16'h7F01);
            end
            pl = aud_adclrck;
            pbm = bclk_mon;
        end
        check("bclk waveform errs", bad_b, 0);
        check("lrck waveform errs", bad_l, 0);
        check("valid pulse errs", bad_v, 0);
        check("lrck first rise", first_rise, 1152);
        check("lrck on bclk fall errs", bad_c, 0);

        // Frame-level table, each row spans one LRCK rising edge to the next
        #2 rst_n = 1'b0;
        enable = 1'b0;
        sample_ready = 1'b0;
        repeat (2) tick();
        @(posedge xck_clock);
        #3 rst_n = 1'b1;
        repeat (1153) tick();
        for (int i = 0; i < 11; i++) begin
            for (int c = 1; c <= 2304; c++) begin
                enable = tbl[i].en && !(tbl[i].gap && c > 500 && c <= 600);
                overrun_clear = tbl[i].clr && (c == 100);
                sample_ready = (c == 2304) ? tbl[i].rdy_last : tbl[i].rdy;
                lw = tbl[i].lw;
                rw = tbl[i].rw;
                tick();
            end
            check($sformatf("row%0d valid", i), sample_valid, tbl[i].exp_v);
            check($sformatf("row%0d left", i), left_sample, tbl[i].exp_l);
            check($sformatf("row%0d right", i), right_sample, tbl[i].exp_r);
            check($sformatf("row%0d overrun", i), overrun, tbl[i].exp_o);
        end

        // Reset in the middle of a right half with a pair pending
        sample_ready = 1'b0;
        repeat (1700) tick();
        check("pre-reset valid", sample_valid, 1);
        check("pre-reset lrck right half", aud_adclrck, 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid reset lrck", aud_adclrck, 0);
        check("mid reset bclk", bclk_mon, 0);
        check("mid reset left", left_sample, 0);
        check("mid reset right", right_sample, 0);
        check("mid reset valid", sample_valid, 0);
        check("mid reset overrun", overrun, 0);
        @(posedge xck_clock);
        @(posedge xck_clock);
        #3 rst_n = 1'b1;
        enable = 1'b1;
        lw = 16'h1357;
        rw = 16'h2468;
        early = 0;
        for (int n = 1; n <= 3457; n++) begin
            tick();
            if (n < 3457 && sample_valid !== 1'b0) early++;
        end
        check("post-reset early valid", early, 0);
        check("post-reset valid", sample_valid, 1);
        check("post-reset left", left_sample, 16'h1357);
        check("post-reset right", right_sample, 16'h2468);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/codec_adc_receiver.md
Name: codec_adc_receiver

Overview:
- Capture path of the audio codec interface: deserializes AUD_ADCDAT into 16-bit two's-complement left/right sample pairs.
- Codec is in left-justified slave mode. This block generates ADCLRCK and an internal BCLK replica from xck_clock.
- The dividers are identical to the DAC side, so the BCLK replica is bit-identical to the DAC-side BCLK when both share xck_clock and rst_n.
- Completed pairs are presented on a valid/ready interface with sticky overrun reporting.

Parameters:
BCLK_DIVIDER, 35, BCLK toggles when its counter reaches this value (18.432 MHz / 512 kHz - 1).
LRCK_DIVIDER, 1151, ADCLRCK toggles when its counter reaches this value (18.432 MHz / 16 kHz - 1).
SAMPLE_WIDTH, 16, bits captured per channel, MSB first.

Ports:
xck_clock  in  1  codec master clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  capture enable
aud_adcdat  in  1  serial ADC data from codec
aud_adclrck  out  1  ADC channel clock: 1 = left, 0 = right
bclk_mon  out  1  internal BCLK replica, for test and monitoring only
left_sample  out  SAMPLE_WIDTH  left channel of the presented pair
right_sample  out  SAMPLE_WIDTH  right channel of the presented pair
sample_valid  out  1  pair available
sample_ready  in  1  consumer accepts the pair
overrun  out  1  sticky: a completed pair was dropped
overrun_clear  in  1  clears overrun

Behaviour:
- Reset values: aud_adclrck=0, bclk_mon=0, left_sample=0, right_sample=0, sample_valid=0, overrun=0. All counters, shift registers and flags are 0.
- Clock generation:
  - Two free-running counters, each wraps to 0 and toggles its clock on reaching its divider value.
  - The counters run regardless of enable.
  - With default parameters, each ADCLRCK edge coincides with a BCLK falling edge. Each LRCK half contains exactly 16 BCLK periods.
- Input path: aud_adcdat is registered once on every xck edge (adc_q).
- Capture strobe:
  - bclk_rise is asserted in the cycle where the BCLK counter equals BCLK_DIVIDER and bclk_mon=0.
  - On bclk_rise with enable=1 and bit_cnt<SAMPLE_WIDTH: shift adc_q into the LSB of the channel shift register and increment bit_cnt.
  - When bit_cnt=SAMPLE_WIDTH, further bits in the same half are ignored (saturate).
- LRCK toggle:
  - bit_cnt clears to 0 in the same cycle the toggle occurs.
  - The shift register for the current channel is selected by the post-toggle aud_adclrck value.
- Left completion: on the falling LRCK toggle (end of left half), left_done is set if bit_cnt=SAMPLE_WIDTH and enable=1, otherwise it is cleared.
- Pair completion:
  - Occurs on the rising LRCK toggle (end of right half) if left_done=1, right bit_cnt=SAMPLE_WIDTH and enable=1.
  - The pair is loaded into the output registers on the next xck edge, so outputs update 1 cycle after the aud_adclrck rising edge.
  - left_done clears after every rising toggle.
  - The first right half after reset never completes a pair (left_done=0).
- Handshake:
  - sample_valid stays high, with data stable, until a cycle with sample_valid=1 and sample_ready=1.
  - On accept with no new pair in that cycle, sample_valid drops the next cycle.
  - New pair while sample_valid=1 and sample_ready=0: the new pair is dropped, output data is unchanged, and overrun is set.
  - New pair in the same cycle as an accept: the new pair loads, sample_valid stays 1, no overrun.
- Overrun: overrun_clear clears overrun. If set and clear occur in the same cycle, set wins.
- enable=0:
  - bit_cnt and left_done are held at 0 and no pairs complete.
  - A pending sample_valid and its data are held until accepted.
  - Re-enabling mid-frame yields no pair until a full left half followed by a full right half is captured.
- Reset mid-operation: all state returns to reset values immediately. A pending pair is lost and overrun clears.

Test Plan:
- Reset, then run 2304×3 xck cycles -> bclk_mon period 72 cycles; aud_adclrck period 2304 cycles, first rising edge at cycle 1152; aud_adclrck edges coincide with bclk_mon falling edges.
- Codec model drives left=16'hA5C3, right=16'h7F01 MSB-first on bclk falls, enable=1, sample_ready=1 -> first pair at the second aud_adclrck rising edge + 1 cycle; left_sample=A5C3, right_sample=7F01; sample_valid pulses for 1 cycle.
- Hold sample_ready=0 across two frames (pair1 0x1111/0x2222, pair2 0x3333/0x4444) -> outputs stay at 1111/2222 and overrun=1; after sample_ready=1 then overrun_clear, overrun=0.
- Assert sample_ready in the exact cycle pair2 completes -> pair2 loads, sample_valid stays 1, overrun stays 0.
- Deassert enable in the middle of the left half, then reassert -> no pair for that frame; next full frame yields the correct pair.
- Assert rst_n=0 mid right half with sample_valid=1 -> all outputs 0 immediately; first pair after release appears at the second aud_adclrck rising edge + 1 cycle.
